// File: rtl/ball_physics_engine.sv
// Ball physics engine for Pong: frame-tick generation, wall and racket
// bounces, miss detection and the serve / move / scored state machine.
// All ball outputs come straight from registers.
module ball_physics_engine #(
    parameter int DISPLAY_W      = 639,
    parameter int DISPLAY_H      = 479,
    parameter int BALL_SIZE      = 15,
    parameter int RACKET_LEFT_X  = 40,
    parameter int RACKET_RIGHT_X = 599,
    parameter int RACKET_W       = 10,
    parameter int RACKET_H       = 70,
    parameter int STEP           = 4,
    parameter int TICK_DIV       = 416667,
    parameter int SERVE_TICKS    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic [9:0] left_racket_y,
    input  logic [9:0] right_racket_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_dir_x,
    output logic       ball_dir_y,
    output logic       point_left,
    output logic       point_right,
    output logic       game_reset,
    output logic       serving
);

    // Geometry constants, all carried at 11 bits so sums never wrap.
    localparam logic [10:0] CX     = 11'((DISPLAY_W - BALL_SIZE) / 2);
    localparam logic [10:0] CY     = 11'((DISPLAY_H - BALL_SIZE) / 2);
    localparam logic [10:0] X_MAX  = 11'(DISPLAY_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(DISPLAY_H - BALL_SIZE);
    localparam logic [10:0] FL     = 11'(RACKET_LEFT_X + RACKET_W);
    localparam logic [10:0] FR     = 11'(RACKET_RIGHT_X - BALL_SIZE);
    localparam logic [10:0] STEP_V = 11'(STEP);
    localparam logic [10:0] BS_V   = 11'(BALL_SIZE);
    localparam logic [10:0] RH_V   = 11'(RACKET_H);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SERVE_MAX = SW'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SCORED = 2'd2
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_serve_cnt;
    logic [9:0]    r_ball_x;
    logic [9:0]    r_ball_y;
    logic          r_dir_x;
    logic          r_dir_y;
    logic          r_point_left;
    logic          r_point_right;
    logic          r_game_reset;
    logic          r_serving;

    logic          w_tick;
    logic [10:0]   w_x;
    logic [10:0]   w_y;
    logic [10:0]   w_ly;
    logic [10:0]   w_ry;
    logic          w_left_ovl;
    logic          w_right_ovl;
    logic [9:0]    w_nx;
    logic [9:0]    w_ny;
    logic          w_ndx;
    logic          w_ndy;
    logic          w_exit_left;
    logic          w_exit_right;

    assign w_tick      = (r_tick_cnt == TICK_MAX) && !pause;
    assign w_x         = {1'b0, r_ball_x};
    assign w_y         = {1'b0, r_ball_y};
    assign w_ly        = {1'b0, left_racket_y};
    assign w_ry        = {1'b0, right_racket_y};
    // Overlap uses the ball row before this tick's vertical update.
    assign w_left_ovl  = ((w_y + BS_V) > w_ly) && (w_y < (w_ly + RH_V));
    assign w_right_ovl = ((w_y + BS_V) > w_ry) && (w_y < (w_ry + RH_V));

    // Vertical step with clamping bounce at the top and bottom walls.
    always_comb begin
        w_ny  = r_ball_y;
        w_ndy = r_dir_y;
        if (r_dir_y) begin
            if (w_y < STEP_V) begin
                w_ny  = 10'd0;
                w_ndy = 1'b0;
            end else begin
                w_ny  = 10'(w_y - STEP_V);
            end
        end else begin
            if ((w_y + STEP_V) >= Y_MAX) begin
                w_ny  = 10'(Y_MAX);
                w_ndy = 1'b1;
            end else begin
                w_ny  = 10'(w_y + STEP_V);
            end
        end
    end

    // Horizontal step: racket face snap-and-bounce, edge exit, or plain move.
    always_comb begin
        w_nx         = r_ball_x;
        w_ndx        = r_dir_x;
        w_exit_left  = 1'b0;
        w_exit_right = 1'b0;
        if (!r_dir_x) begin
            if ((w_x >= FL) && ((w_x - STEP_V) < FL) && w_left_ovl) begin
                w_nx  = 10'(FL);
                w_ndx = 1'b1;
            end else if (w_x < STEP_V) begin
                w_exit_left = 1'b1;
            end else begin
                w_nx = 10'(w_x - STEP_V);
            end
        end else begin
            if ((w_x <= FR) && ((w_x + STEP_V) > FR) && w_right_ovl) begin
                w_nx  = 10'(FR);
                w_ndx = 1'b0;
            end else if ((w_x + STEP_V) > X_MAX) begin
                w_exit_right = 1'b1;
            end else begin
                w_nx = 10'(w_x + STEP_V);
            end
        end
    end

    // Tick divider plus serve/move/scored state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_SERVE;
            r_tick_cnt    <= '0;
            r_serve_cnt   <= '0;
            r_ball_x      <= 10'(CX);
            r_ball_y      <= 10'(CY);
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b0;
            r_point_left  <= 1'b0;
            r_point_right <= 1'b0;
            r_game_reset  <= 1'b0;
            r_serving     <= 1'b1;
        end else begin
            r_point_left  <= 1'b0;
            r_point_right <= 1'b0;
            r_game_reset  <= 1'b0;
            if (!pause) begin
                r_tick_cnt <= (r_tick_cnt == TICK_MAX) ? '0 : r_tick_cnt + TW'(1);
            end
            case (r_state)
                ST_SERVE: begin
                    r_ball_x <= 10'(CX);
                    r_ball_y <= 10'(CY);
                    if (w_tick) begin
                        if (r_serve_cnt == SERVE_MAX) begin
                            r_serve_cnt <= '0;
                            r_state     <= ST_MOVE;
                            r_serving   <= 1'b0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + SW'(1);
                        end
                    end
                end
                ST_MOVE: begin
                    if (w_tick) begin
                        r_ball_y <= w_ny;
                        r_dir_y  <= w_ndy;
                        if (w_exit_left) begin
                            r_point_right <= 1'b1;
                            r_state       <= ST_SCORED;
                        end else if (w_exit_right) begin
                            r_point_left <= 1'b1;
                            r_state      <= ST_SCORED;
                        end else begin
                            r_ball_x <= w_nx;
                            r_dir_x  <= w_ndx;
                        end
                    end
                end
                ST_SCORED: begin
                    // Direction already points at the conceding player, so it is kept.
                    r_game_reset <= 1'b1;
                    r_ball_x     <= 10'(CX);
                    r_ball_y     <= 10'(CY);
                    r_serving    <= 1'b1;
                    r_state      <= ST_SERVE;
                end
                default: begin
                    r_state   <= ST_SERVE;
                    r_serving <= 1'b1;
                end
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign ball_dir_x  = r_dir_x;
    assign ball_dir_y  = r_dir_y;
    assign point_left  = r_point_left;
    assign point_right = r_point_right;
    assign game_reset  = r_game_reset;
    assign serving     = r_serving;

endmodule
